if_prefetch: RTL and testbench
==============================

IF_PREFETCH -- requirements
Module: if_prefetch

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning address/instruction width.
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning prefetch buffer entries; power of two, at least 2.
REQ-003 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning first fetch address after reset.
REQ-004 The block SHALL have the port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have the port rst_n, input, 1, meaning reset; synchronous, active-low.
REQ-006 The block SHALL have the port imem_req_valid, output, 1, meaning a fetch request is presented.
REQ-007 The block SHALL have the port imem_req_addr, output, XLEN, meaning the word-aligned fetch address.
REQ-008 The block SHALL have the port imem_req_ready, input, 1, meaning memory accepts the request this cycle.
REQ-009 The block SHALL have the port imem_rsp_valid, input, 1, meaning instruction data returns; in order, at least 1 cycle after acceptance.
REQ-010 The block SHALL have the port imem_rsp_data, input, XLEN, meaning the returned instruction word.
REQ-011 The block SHALL have the port redirect_valid, input, 1, meaning a branch/jump redirect.
REQ-012 The block SHALL have the port redirect_target, input, XLEN, meaning the new fetch address.
REQ-013 The block SHALL have the port inst_valid, output, 1, meaning the buffer head is valid for decode.
REQ-014 The block SHALL have the port inst, output, XLEN, meaning the buffer head instruction.
REQ-015 The block SHALL have the port inst_pc, output, XLEN, meaning the address of inst.
REQ-016 The block SHALL have the port inst_ready, input, 1, meaning decode consumes the head this cycle.

Function
REQ-017 The block SHALL accept a request when imem_req_valid and imem_req_ready are both 1; fetch_pc then advances by 4.
REQ-018 The block SHALL assert imem_req_valid only while (outstanding + buffer count) < DEPTH, guaranteeing every response a slot.
REQ-019 imem_req_addr SHALL equal fetch_pc, and SHALL be held stable while imem_req_valid=1 and imem_req_ready=0, unless a redirect occurs.
REQ-020 The block SHALL write each non-dropped response into the FIFO tail with its PC, taken from an internal PC queue of outstanding addresses.
REQ-021 The block SHALL drive inst_valid=1 whenever the FIFO is non-empty; inst and inst_pc SHALL come from the head combinationally; a pop occurs when inst_valid and inst_ready are both 1.
REQ-022 Push and pop in the same cycle SHALL leave the count unchanged, including when the FIFO is full; pointers SHALL wrap modulo DEPTH.
REQ-023 An empty-FIFO response SHALL appear on inst_valid the cycle after imem_rsp_valid; there is no bypass.
REQ-024 On redirect_valid=1, the block SHALL, in that same clock edge:
  - set fetch_pc to redirect_target with bits [1:0] forced to 0;
  - empty the FIFO, with any pop that cycle ignored;
  - load drop_cnt with the outstanding count, including any request accepted that cycle.
REQ-025 During a redirect cycle, the block SHALL drive imem_req_valid=0, and it SHALL also discard any response arriving in that cycle.
REQ-026 While drop_cnt>0, each imem_rsp_valid SHALL decrement drop_cnt and SHALL be discarded, with no FIFO write.
REQ-027 A redirect while drop_cnt>0 SHALL reload drop_cnt with the total outstanding count.
REQ-028 The outstanding counter SHALL increment on acceptance and decrement on response; both in one cycle SHALL leave it unchanged; it SHALL never exceed DEPTH.
REQ-029 fetch_pc SHALL wrap from 32'hFFFF_FFFC to 0 without error.
REQ-030 An imem_rsp_valid with outstanding=0 SHALL be ignored, so it SHALL NOT underflow the counter.

Reset
REQ-031 While rst_n=0 at a clock edge, the block SHALL set fetch_pc=RESET_PC, FIFO pointers and count=0, outstanding=0, and drop_cnt=0.
REQ-032 During reset and in the first cycle after it, imem_req_valid and inst_valid SHALL be 0; inst and inst_pc values are don't-care while inst_valid=0.
REQ-033 Reset mid-operation SHALL discard all buffered and in-flight instructions, and later responses SHALL be ignored per REQ-030.
REQ-034 rst_n SHALL take priority over redirect_valid.

Verification
REQ-035 Reset then streaming: rst_n low 2 cycles, then high; memory 1-cycle latency, inst_ready=1 -> requests at 0,4,8,...; inst_pc sequence 0,4,8 with matching data; one instruction per cycle once streaming.
REQ-036 Backpressure: inst_ready=0 with DEPTH=4 -> exactly 4 requests accepted (0,4,8,C), then imem_req_valid=0; release inst_ready -> head 0, then 4, 8, C in order, and fetching resumes at 0x10.
REQ-037 Redirect with in-flight responses: 2 requests outstanding, redirect_target=0x103 -> both returning responses discarded; next request addr 0x100; first inst_pc=0x100.
REQ-038 Memory stall: imem_req_ready=0 for 5 cycles -> imem_req_addr stable, no FIFO writes; redirect during the stall changes addr next cycle.
REQ-039 Simultaneous push/pop with FIFO full and inst_ready=1 -> count stays DEPTH, order preserved, no loss.
REQ-040 Reset mid-stream with 3 outstanding -> after release, fetch restarts at RESET_PC; stale responses do not reach inst_valid.

Source files
------------

// File: rtl/if_prefetch_if.sv
// Fetch-side bus bundle for if_prefetch: imem request/response,
// redirect input and decode-facing instruction handshake.
interface if_prefetch_if #(
    parameter int XLEN = 32
);
    logic            imem_req_valid;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_req_ready;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_target;
    logic            inst_valid;
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] inst_pc;
    logic            inst_ready;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data,
        input  redirect_valid,
        input  redirect_target,
        output inst_valid,
        output inst,
        output inst_pc,
        input  inst_ready
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data,
        output redirect_valid,
        output redirect_target,
        input  inst_valid,
        input  inst,
        input  inst_pc,
        output inst_ready
    );
endinterface

// File: rtl/if_prefetch.sv
// Instruction prefetcher: in-order imem fetch into a DEPTH-entry buffer,
// with redirect flush and drop counting of stale in-flight responses.
module if_prefetch #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h0000_0000)
) (
    input logic           clk,
    input logic           rst_n,
    if_prefetch_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef logic [XLEN-1:0] word_t;

    word_t         fetch_pc_q, fetch_pc_d;
    logic          run_q;
    logic [CW-1:0] out_cnt_q, out_cnt_d;
    logic [CW-1:0] drop_cnt_q, drop_cnt_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] pq_wr_q, pq_wr_d;
    logic [PW-1:0] pq_rd_q, pq_rd_d;

    word_t fifo_data_q [DEPTH];
    word_t fifo_pc_q   [DEPTH];
    word_t pcq_q       [DEPTH];

    logic          redir;
    logic [CW:0]   used;
    logic          req_valid;
    logic          acc;
    logic          rsp_hit;
    logic          push;
    logic          inst_valid;
    logic          pop;

    always_comb begin
        redir      = bus.redirect_valid;
        used       = {1'b0, out_cnt_q} + {1'b0, cnt_q};
        // Only request when every outstanding response has a free slot.
        req_valid  = rst_n & run_q & ~redir & (used < (CW+1)'(DEPTH));
        acc        = req_valid & bus.imem_req_ready;
        rsp_hit    = bus.imem_rsp_valid & (out_cnt_q != '0);
        push       = rsp_hit & ~redir & (drop_cnt_q == '0);
        inst_valid = rst_n & (cnt_q != '0);
        pop        = inst_valid & bus.inst_ready & ~redir;

        out_cnt_d  = out_cnt_q + CW'(acc) - CW'(rsp_hit);

        drop_cnt_d = drop_cnt_q;
        if (redir) begin
            drop_cnt_d = out_cnt_d;
        end else if (rsp_hit && drop_cnt_q != '0) begin
            drop_cnt_d = drop_cnt_q - CW'(1);
        end

        fetch_pc_d = fetch_pc_q;
        if (redir) begin
            fetch_pc_d = bus.redirect_target & ~word_t'(3);
        end else if (acc) begin
            fetch_pc_d = fetch_pc_q + word_t'(4);
        end

        cnt_d    = cnt_q + CW'(push) - CW'(pop);
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        if (redir) begin
            cnt_d    = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end

        // Outstanding-PC queue tracks every request, dropped or not.
        pq_wr_d = pq_wr_q + PW'(acc);
        pq_rd_d = pq_rd_q + PW'(rsp_hit);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            run_q      <= 1'b0;
            out_cnt_q  <= '0;
            drop_cnt_q <= '0;
            cnt_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            pq_wr_q    <= '0;
            pq_rd_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            run_q      <= 1'b1;
            out_cnt_q  <= out_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            cnt_q      <= cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            pq_wr_q    <= pq_wr_d;
            pq_rd_q    <= pq_rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (acc) begin
            pcq_q[pq_wr_q] <= fetch_pc_q;
        end
        if (push) begin
            fifo_data_q[wr_ptr_q] <= bus.imem_rsp_data;
            fifo_pc_q[wr_ptr_q]   <= pcq_q[pq_rd_q];
        end
    end

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = fetch_pc_q;
    assign bus.inst_valid     = inst_valid;
    assign bus.inst           = fifo_data_q[rd_ptr_q];
    assign bus.inst_pc        = fifo_pc_q[rd_ptr_q];

endmodule

// File: tb/tb_if_prefetch.sv
// Randomized and directed bench for if_prefetch with an in-order
// memory model and a sequential-PC reference of the fetch stream.
module tb_if_prefetch;
    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    logic clk;
    logic rst_n;

    if_prefetch_if #(.XLEN(32)) bus ();

    if_prefetch #(
        .XLEN(32),
        .DEPTH(DEPTH),
        .RESET_PC(RPC)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int base = 0;
    int lat = 1;
    int last_due = 0;

    mreq_t       mem_q[$];
    logic [31:0] acc_q[$];
    int          acc_cyc_q[$];
    logic [31:0] pop_pc_q[$];
    logic [31:0] pop_dat_q[$];
    int          pop_cyc_q[$];

    logic        o_rv, o_iv;
    logic [31:0] o_ra, o_ipc, o_inst;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic clear_logs();
        acc_q.delete();
        acc_cyc_q.delete();
        pop_pc_q.delete();
        pop_dat_q.delete();
        pop_cyc_q.delete();
    endtask

    // One clock cycle: memory drives, outputs sampled, events logged.
    task automatic tick();
        mreq_t m;
        int    due;
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            m = mem_q.pop_front();
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = mem_word(m.addr);
        end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = $urandom;
        end
        #1;
        o_rv   = bus.imem_req_valid;
        o_ra   = bus.imem_req_addr;
        o_iv   = bus.inst_valid;
        o_ipc  = bus.inst_pc;
        o_inst = bus.inst;
        if (rst_n && o_rv && bus.imem_req_ready) begin
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            m.addr = o_ra;
            m.due  = due;
            mem_q.push_back(m);
            acc_q.push_back(o_ra);
            acc_cyc_q.push_back(cyc);
        end
        if (rst_n && o_iv && bus.inst_ready && !bus.redirect_valid) begin
            pop_pc_q.push_back(o_ipc);
            pop_dat_q.push_back(o_inst);
            pop_cyc_q.push_back(cyc);
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.redirect_valid = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        mem_q.delete();
        last_due = 0;
        clear_logs();
        base = cyc;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.imem_req_ready = 1'b1;
        bus.inst_ready = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_target = '0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (o_rv !== 1'b0) begin
                errors++;
                $display("FAIL rst_req_valid got %b want 0", o_rv);
            end
            checks++;
            if (o_iv !== 1'b0) begin
                errors++;
                $display("FAIL rst_inst_valid got %b want 0", o_iv);
            end
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (o_rv !== 1'b0 || o_iv !== 1'b0) begin
            errors++;
            $display("FAIL post_rst_valids got %b%b want 00", o_rv, o_iv);
        end
        mem_q.delete();
    endtask

    task automatic test_stream();
        do_reset();
        lat = 1;
        bus.imem_req_ready = 1'b1;
        bus.inst_ready = 1'b1;
        repeat (20) tick();
        checks++;
        if (acc_cyc_q.size() == 0 || acc_cyc_q[0] - base != 1) begin
            errors++;
            $display("FAIL stream_first_req got %0d want 1",
                     acc_cyc_q.size() ? acc_cyc_q[0] - base : -1);
        end
        for (int i = 0; i < acc_q.size(); i++) begin
            checks++;
            if (acc_q[i] !== 32'(i * 4)) begin
                errors++;
                $display("FAIL stream_req_addr got %h want %h",
                         acc_q[i], 32'(i * 4));
            end
        end
        checks++;
        if (pop_cyc_q.size() == 0 || pop_cyc_q[0] - base != 3) begin
            errors++;
            $display("FAIL stream_first_inst got %0d want 3",
                     pop_cyc_q.size() ? pop_cyc_q[0] - base : -1);
        end
        checks++;
        if (pop_pc_q.size() != 17) begin
            errors++;
            $display("FAIL stream_rate got %0d want 17", pop_pc_q.size());
        end
        for (int i = 0; i < pop_pc_q.size(); i++) begin
            checks++;
            if (pop_pc_q[i] !== 32'(i * 4) ||
                pop_dat_q[i] !== mem_word(32'(i * 4))) begin
                errors++;
                $display("FAIL stream_inst got %h/%h want %h/%h",
                         pop_pc_q[i], pop_dat_q[i],
                         32'(i * 4), mem_word(32'(i * 4)));
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        lat = 1;
        bus.imem_req_ready = 1'b1;
        bus.inst_ready = 1'b0;
        repeat (10) tick();
        checks++;
        if (acc_q.size() != DEPTH) begin
            errors++;
            $display("FAIL bp_req_count got %0d want %0d",
                     acc_q.size(), DEPTH);
        end
        for (int i = 0; i < acc_q.size(); i++) begin
            checks++;
            if (acc_q[i] !== 32'(i * 4)) begin
                errors++;
                $display("FAIL bp_req_addr got %h want %h",
                         acc_q[i], 32'(i * 4));
            end
        end
        checks++;
        if (o_rv !== 1'b0 || o_iv !== 1'b1 || o_ipc !== 32'h0) begin
            errors++;
            $display("FAIL bp_full got rv=%b iv=%b pc=%h want 0 1 0",
                     o_rv, o_iv, o_ipc);
        end
        clear_logs();
        bus.inst_ready = 1'b1;
        repeat (12) tick();
        checks++;
        if (acc_q.size() == 0 || acc_q[0] !== 32'h10) begin
            errors++;
            $display("FAIL bp_resume got %h want 00000010",
                     acc_q.size() ? acc_q[0] : 32'hx);
        end
        checks++;
        if (pop_pc_q.size() < 8) begin
            errors++;
            $display("FAIL bp_drain got %0d want >=8", pop_pc_q.size());
        end
        for (int i = 0; i < pop_pc_q.size(); i++) begin
            checks++;
            if (pop_pc_q[i] !== 32'(i * 4) ||
                pop_dat_q[i] !== mem_word(32'(i * 4))) begin
                errors++;
                $display("FAIL bp_order got %h want %h",
                         pop_pc_q[i], 32'(i * 4));
            end
        end
    endtask

    task automatic test_redirect();
        do_reset();
        lat = 3;
        bus.imem_req_ready = 1'b1;
        bus.inst_ready = 1'b1;
        repeat (3) tick();
        checks++;
        if (acc_q.size() != 2 || mem_q.size() != 2) begin
            errors++;
            $display("FAIL redir_setup got %0d/%0d want 2/2",
                     acc_q.size(), mem_q.size());
        end
        bus.redirect_valid = 1'b1;
        bus.redirect_target = 32'h103;
        tick();
        checks++;
        if (o_rv !== 1'b0) begin
            errors++;
            $display("FAIL redir_req_valid got %b want 0", o_rv);
        end
        bus.redirect_valid = 1'b0;
        clear_logs();
        lat = 1;
        repeat (15) tick();
        checks++;
        if (acc_q.size() == 0 || acc_q[0] !== 32'h100) begin
            errors++;
            $display("FAIL redir_addr got %h want 00000100",
                     acc_q.size() ? acc_q[0] : 32'hx);
        end
        checks++;
        if (pop_pc_q.size() < 4) begin
            errors++;
            $display("FAIL redir_pops got %0d want >=4", pop_pc_q.size());
        end
        for (int i = 0; i < pop_pc_q.size(); i++) begin
            checks++;
            if (pop_pc_q[i] !== 32'h100 + 32'(i * 4) ||
                pop_dat_q[i] !== mem_word(32'h100 + 32'(i * 4))) begin
                errors++;
                $display("FAIL redir_inst got %h want %h",
                         pop_pc_q[i], 32'h100 + 32'(i * 4));
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] a0;
        do_reset();
        lat = 1;
        bus.imem_req_ready = 1'b1;
        bus.inst_ready = 1'b1;
        repeat (6) tick();
        bus.imem_req_ready = 1'b0;
        clear_logs();
        tick();
        a0 = o_ra;
        checks++;
        if (o_rv !== 1'b1 || a0 !== 32'h14) begin
            errors++;
            $display("FAIL stall_start got %b/%h want 1/00000014",
                     o_rv, a0);
        end
        repeat (4) begin
            tick();
            checks++;
            if (o_ra !== a0 || o_rv !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold got %b/%h want 1/%h",
                         o_rv, o_ra, a0);
            end
        end
        checks++;
        if (o_iv !== 1'b0 || pop_pc_q.size() != 2) begin
            errors++;
            $display("FAIL stall_nowrite got iv=%b pops=%0d want 0 2",
                     o_iv, pop_pc_q.size());
        end
        bus.redirect_valid = 1'b1;
        bus.redirect_target = 32'h2000;
        tick();
        checks++;
        if (o_rv !== 1'b0) begin
            errors++;
            $display("FAIL stall_redir_valid got %b want 0", o_rv);
        end
        bus.redirect_valid = 1'b0;
        tick();
        checks++;
        if (o_ra !== 32'h2000 || o_rv !== 1'b1) begin
            errors++;
            $display("FAIL stall_redir_addr got %b/%h want 1/00002000",
                     o_rv, o_ra);
        end
        bus.imem_req_ready = 1'b1;
        clear_logs();
        repeat (8) tick();
        checks++;
        if (pop_pc_q.size() == 0 || pop_pc_q[0] !== 32'h2000) begin
            errors++;
            $display("FAIL stall_resume got %h want 00002000",
                     pop_pc_q.size() ? pop_pc_q[0] : 32'hx);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        lat = 1;
        bus.imem_req_ready = 1'b1;
        bus.inst_ready = 1'b0;
        repeat (8) tick();
        checks++;
        if (o_rv !== 1'b0 || o_iv !== 1'b1) begin
            errors++;
            $display("FAIL full_state got rv=%b iv=%b want 0 1", o_rv, o_iv);
        end
        clear_logs();
        bus.inst_ready = 1'b1;
        repeat (12) tick();
        checks++;
        if (pop_pc_q.size() != 12) begin
            errors++;
            $display("FAIL full_rate got %0d want 12", pop_pc_q.size());
        end
        for (int i = 0; i < pop_pc_q.size(); i++) begin
            checks++;
            if (pop_pc_q[i] !== 32'(i * 4) ||
                pop_dat_q[i] !== mem_word(32'(i * 4))) begin
                errors++;
                $display("FAIL full_order got %h want %h",
                         pop_pc_q[i], 32'(i * 4));
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.redirect_valid = 1'b1;
        bus.redirect_target = 32'h4000;
        tick();
        bus.redirect_valid = 1'b0;
        lat = 3;
        bus.imem_req_ready = 1'b1;
        bus.inst_ready = 1'b0;
        repeat (3) tick();
        checks++;
        if (mem_q.size() != 3) begin
            errors++;
            $display("FAIL rmid_inflight got %0d want 3", mem_q.size());
        end
        bus.imem_req_ready = 1'b0;
        rst_n = 1'b0;
        repeat (2) begin
            tick();
            checks++;
            if (o_rv !== 1'b0 || o_iv !== 1'b0) begin
                errors++;
                $display("FAIL rmid_in_rst got %b%b want 00", o_rv, o_iv);
            end
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (o_rv !== 1'b0 || o_iv !== 1'b0) begin
            errors++;
            $display("FAIL rmid_post got %b%b want 00", o_rv, o_iv);
        end
        clear_logs();
        lat = 1;
        bus.imem_req_ready = 1'b1;
        bus.inst_ready = 1'b1;
        repeat (12) tick();
        checks++;
        if (acc_q.size() == 0 || acc_q[0] !== RPC) begin
            errors++;
            $display("FAIL rmid_restart got %h want %h",
                     acc_q.size() ? acc_q[0] : 32'hx, RPC);
        end
        checks++;
        if (pop_pc_q.size() < 4) begin
            errors++;
            $display("FAIL rmid_pops got %0d want >=4", pop_pc_q.size());
        end
        for (int i = 0; i < pop_pc_q.size(); i++) begin
            checks++;
            if (pop_pc_q[i] !== RPC + 32'(i * 4) ||
                pop_dat_q[i] !== mem_word(RPC + 32'(i * 4))) begin
                errors++;
                $display("FAIL rmid_inst got %h want %h",
                         pop_pc_q[i], RPC + 32'(i * 4));
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] exp_f, exp_p, tgt, prev_a;
        logic        prev_stall;
        do_reset();
        exp_f = RPC;
        exp_p = RPC;
        prev_stall = 1'b0;
        prev_a = '0;
        for (int it = 0; it < 600; it++) begin
            bus.imem_req_ready = ($urandom % 4) != 0;
            bus.inst_ready = ($urandom % 3) != 0;
            lat = 1 + int'($urandom % 3);
            tgt = (it == 300) ? 32'hFFFF_FFF6 : $urandom;
            bus.redirect_valid = ($urandom % 25) == 0 || it == 300;
            bus.redirect_target = tgt;
            clear_logs();
            tick();
            if (prev_stall) begin
                checks++;
                if (o_ra !== prev_a) begin
                    errors++;
                    $display("FAIL rnd_hold got %h want %h", o_ra, prev_a);
                end
            end
            prev_stall = o_rv && !bus.imem_req_ready &&
                         !bus.redirect_valid;
            prev_a = o_ra;
            if (bus.redirect_valid) begin
                checks++;
                if (o_rv !== 1'b0) begin
                    errors++;
                    $display("FAIL rnd_redir_valid got %b want 0", o_rv);
                end
                exp_f = tgt & 32'hFFFF_FFFC;
                exp_p = exp_f;
            end else begin
                if (acc_q.size() > 0) begin
                    checks++;
                    if (acc_q[0] !== exp_f) begin
                        errors++;
                        $display("FAIL rnd_req_addr got %h want %h",
                                 acc_q[0], exp_f);
                    end
                    exp_f = exp_f + 32'd4;
                end
                if (pop_pc_q.size() > 0) begin
                    checks++;
                    if (pop_pc_q[0] !== exp_p ||
                        pop_dat_q[0] !== mem_word(exp_p)) begin
                        errors++;
                        $display("FAIL rnd_inst got %h/%h want %h/%h",
                                 pop_pc_q[0], pop_dat_q[0],
                                 exp_p, mem_word(exp_p));
                    end
                    exp_p = exp_p + 32'd4;
                end
            end
        end
        bus.redirect_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data = '0;
        bus.redirect_valid = 1'b0;
        bus.redirect_target = '0;
        bus.inst_ready = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
